ps2_kbd_rx: RTL and testbench

Parametrised PS/2 keyboard receiver, successor to the single-register scan-code decoder. It oversamples PS2_CLK/PS2_DATA in the system clock domain and checks start, parity and stop bits. A watchdog recovers from truncated frames. E0/F0 prefixes are folded into 10-bit key events, which are buffered in a FIFO with a valid/ready pop interface for the game/UI logic.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_event_fifo.sv | 55 +++++
 rtl/ps2_kbd_rx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 event layout, scan-code prefixes and key-event constants.
// No logic; imported by the receiver and testbench.
package ps2_pkg;

  localparam int EV_W         = 10;
  localparam int EV_CODE_LSB  = 0;
  localparam int EV_CODE_W    = 8;
  localparam int EV_BRK_BIT   = 8;
  localparam int EV_EXT_BIT   = 9;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_ev_t;

  localparam logic [EV_W-1:0] KEY_UP_MK     = 10'h275;
  localparam logic [EV_W-1:0] KEY_UP_BRK    = 10'h375;
  localparam logic [EV_W-1:0] KEY_LEFT_MK   = 10'h26B;
  localparam logic [EV_W-1:0] KEY_LEFT_BRK  = 10'h36B;
  localparam logic [EV_W-1:0] KEY_RIGHT_MK  = 10'h274;
  localparam logic [EV_W-1:0] KEY_RIGHT_BRK = 10'h374;
  localparam logic [EV_W-1:0] KEY_ENTER_MK  = 10'h05A;
  localparam logic [EV_W-1:0] KEY_ENTER_BRK = 10'h15A;

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic synchronous first-word-fall-through FIFO, 2**AW entries of W bits.
// Latency: pushed word visible at o_dat the cycle after the push; a push to a full FIFO is refused unless a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int W  = 10,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_count = r_count;
  assign o_dat   = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: oversampled frame check, watchdog, E0/F0 folding into 10-bit events, FWFT event FIFO; PS2_KEYSTATE_EN adds arrow/enter key state.
// Latency: event pushed the cycle after the 11th falling edge, ev_valid the cycle after; full FIFO drops events and sets sticky overflow.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [EV_W-1:0]            ev_data,
  output logic [FIFO_DEPTH_LOG2:0]   ev_count,
  output logic                       frame_err,
  output logic                       overflow,
  input  logic                       clr_overflow
`ifdef PS2_KEYSTATE_EN
  ,
  output logic                       key_up,
  output logic                       key_left,
  output logic                       key_right,
  output logic                       key_enter
`endif
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  // Synchronisers reset to the idle-high line level so release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= w_clk_s;
    end
  end

  logic [3:0]      r_bit_cnt;
  logic [9:0]      r_frame;
  logic [WD_W-1:0] r_wdog;
  logic            r_byte_vld;
  logic [7:0]      r_byte;
  logic            r_frame_err;
  logic            w_last;
  logic            w_good;
  logic            w_tmo;
  logic            w_abort;

  assign w_last    = w_fall & (r_bit_cnt == 4'd10);
  assign w_good    = ~r_frame[0] & (^r_frame[9:1]) & w_dat_s;
  assign w_tmo     = ~w_fall & (r_bit_cnt != 4'd0) & (r_wdog == WD_W'(TIMEOUT_CYCLES));
  assign w_abort   = (w_last & ~w_good) | w_tmo;
  assign frame_err = r_frame_err;

  // r_frame shifts in from the top: after ten edges bit 0 is start, 8:1 data, 9 parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_frame     <= '0;
      r_wdog      <= '0;
      r_byte_vld  <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_wdog <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt   <= '0;
          r_byte_vld  <= w_good;
          r_frame_err <= ~w_good;
          r_byte      <= r_frame[8:1];
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_frame   <= {w_dat_s, r_frame[9:1]};
        end
      end else if (r_bit_cnt == 4'd0) begin
        r_wdog <= '0;
      end else if (w_tmo) begin
        r_bit_cnt   <= '0;
        r_wdog      <= '0;
        r_frame_err <= 1'b1;
      end else begin
        r_wdog <= r_wdog + WD_W'(1);
      end
    end
  end

  logic    r_ext;
  logic    r_brk;
  logic    w_is_ext;
  logic    w_is_brk;
  logic    w_push;
  logic    w_pop;
  logic    w_full;
  logic    w_empty;
  logic    r_ovf;
  ps2_ev_t w_ev;

  assign w_is_ext = (r_byte == PS2_PREFIX_EXT);
  assign w_is_brk = (r_byte == PS2_PREFIX_BRK);
  assign w_push   = r_byte_vld & ~w_is_ext & ~w_is_brk;
  assign w_ev     = '{ext: r_ext, brk: r_brk, code: r_byte};
  assign w_pop    = ev_ready & ~w_empty;
  assign ev_valid = ~w_empty;
  assign overflow = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_abort) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_vld) begin
        if (w_is_ext)      r_ext <= 1'b1;
        else if (w_is_brk) r_brk <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
      if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
      else if (clr_overflow)        r_ovf <= 1'b0;
    end
  end

  ps2_event_fifo #(
    .W  (EV_W),
    .AW (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_ev),
    .i_pop      (ev_ready),
    .o_dat      (ev_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (ev_count)
  );

`ifdef PS2_KEYSTATE_EN
  // Key state tracks every decoded event, even ones the FIFO drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_up    <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
      key_enter <= 1'b0;
    end else if (w_push) begin
      case (w_ev)
        KEY_UP_MK:     key_up    <= 1'b1;
        KEY_UP_BRK:    key_up    <= 1'b0;
        KEY_LEFT_MK:   key_left  <= 1'b1;
        KEY_LEFT_BRK:  key_left  <= 1'b0;
        KEY_RIGHT_MK:  key_right <= 1'b1;
        KEY_RIGHT_BRK: key_right <= 1'b0;
        KEY_ENTER_MK:  key_enter <= 1'b1;
        KEY_ENTER_BRK: key_enter <= 1'b0;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames on the pins and compares decoded events against hand-computed values.
// Pops are logged on the falling clk edge; frame_err pulses are counted there too.
module tb_ps2_kbd_rx;

  localparam int TMO   = 200;
  localparam int DLOG2 = 3;
  localparam int DEPTH = 1 << DLOG2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ps2_clk = 1'b1;
  logic             ps2_data = 1'b1;
  logic             ev_valid;
  logic             ev_ready = 1'b0;
  logic [9:0]       ev_data;
  logic [DLOG2:0]   ev_count;
  logic             frame_err;
  logic             overflow;
  logic             clr_overflow = 1'b0;
`ifdef PS2_KEYSTATE_EN
  logic             key_up, key_left, key_right, key_enter;
`endif

  int         n_vec  = 0;
  int         n_err  = 0;
  int         n_ferr = 0;
  logic [9:0] evq[$];

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .TIMEOUT_CYCLES  (TMO),
    .FIFO_DEPTH_LOG2 (DLOG2),
    .SYNC_STAGES     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_data      (ev_data),
    .ev_count     (ev_count),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef PS2_KEYSTATE_EN
    ,
    .key_up       (key_up),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_enter    (key_enter)
`endif
  );

  always @(negedge clk) begin
    if (ev_valid && ev_ready) evq.push_back(ev_data);
    if (frame_err) n_ferr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (8) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (8) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ev_ready = v;
  endtask

  task automatic take_ev(input string tag, input logic [9:0] exp);
    logic [9:0] got;
    got = 10'h3FF;
    if (evq.size() != 0) got = evq.pop_front();
    chk(tag, 32'(got), 32'(exp));
  endtask

  int e0;

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_count", 32'(ev_count), 0);
    chk("rst_data",  32'(ev_data), 0);
    chk("rst_ferr",  32'(frame_err), 0);
    chk("rst_ovf",   32'(overflow), 0);
    ev_ready = 1'b1;
    rst = 1'b0;
    idle(5);

    // plain make code
    e0 = n_ferr;
    send(8'h1C);
    idle(20);
    chk("t1_n", 32'(evq.size()), 1);
    take_ev("t1_ev", 10'h01C);
    chk("t1_ferr", 32'(n_ferr - e0), 0);

    // extended break, then flags must be clear
    send(8'hE0); send(8'hF0); send(8'h75);
    idle(20);
    chk("t2_n", 32'(evq.size()), 1);
    take_ev("t2_ev", 10'h375);
    send(8'h1C);
    idle(20);
    take_ev("t2_after", 10'h01C);

    // parity error discards byte and pending E0
    e0 = n_ferr;
    send(8'hE0);
    send_bits(mk_frame(8'h1C, 1'b1), 11);
    idle(20);
    chk("t3_ferr", 32'(n_ferr - e0), 1);
    chk("t3_n", 32'(evq.size()), 0);
    send(8'h1C);
    idle(20);
    take_ev("t3_after", 10'h01C);

    // truncated frame recovered by the watchdog
    e0 = n_ferr;
    send_bits(mk_frame(8'h55, 1'b0), 5);
    idle(TMO + 100);
    chk("t4_ferr", 32'(n_ferr - e0), 1);
    chk("t4_n", 32'(evq.size()), 0);
    send(8'h2A);
    idle(20);
    take_ev("t4_ev", 10'h02A);
    chk("t4_ferr2", 32'(n_ferr - e0), 1);

    // overflow: DEPTH+1 codes with the consumer stalled
    set_ready(1'b0);
    for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i));
    idle(20);
    chk("t5_count", 32'(ev_count), DEPTH);
    chk("t5_ovf", 32'(overflow), 1);
    chk("t5_valid", 32'(ev_valid), 1);
    chk("t5_head", 32'(ev_data), 32'h010);
    set_ready(1'b1);
    idle(20);
    chk("t5_n", 32'(evq.size()), DEPTH);
    for (int i = 0; i < DEPTH; i++) take_ev("t5_pop", 10'h010 + 10'(i));
    chk("t5_empty", 32'(ev_count), 0);
    chk("t5_sticky", 32'(overflow), 1);
    @(posedge clk); #1 clr_overflow = 1'b1;
    @(posedge clk); #1 clr_overflow = 1'b0;
    idle(2);
    chk("t5_clr", 32'(overflow), 0);

`ifdef PS2_KEYSTATE_EN
    // key state updates even while every push is dropped
    set_ready(1'b0);
    for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i));
    send(8'hE0); send(8'h75);
    idle(20);
    chk("t6_count", 32'(ev_count), DEPTH);
    chk("t6_ovf", 32'(overflow), 1);
    chk("t6_up_mk", 32'(key_up), 1);
    chk("t6_left", 32'(key_left), 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    idle(20);
    chk("t6_up_brk", 32'(key_up), 0);
    set_ready(1'b1);
    idle(20);
    evq.delete();
    chk("t6_drain", 32'(ev_count), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
